// File: rtl/key_req_queue_pkg.sv
// Shared types and defaults for the key request queue: FSM state encoding,
// default geometry and the width helper for the wait counter.
package key_req_queue_pkg;

   localparam int DEPTH_DEF   = 4;
   localparam int KEY_W_DEF   = 4;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // Width that holds every value 0..timeout.
   function automatic int wait_width(input int timeout);
      return $clog2(timeout) + 1;
   endfunction

endpackage

// File: rtl/key_req_queue_if.sv
// Upstream key handshake, downstream matcher request/ack and retire report,
// bundled so the queue and its environment share one port list.
interface key_req_queue_if
   import key_req_queue_pkg::*;
#(
   parameter int KEY_W   = KEY_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
);

   logic                            in_valid;
   logic [KEY_W-1:0]                in_key;
   logic                            in_ready;
   logic                            req;
   logic [KEY_W-1:0]                req_key;
   logic                            ack;
   logic                            done_valid;
   logic [KEY_W-1:0]                done_key;
   logic [wait_width(TIMEOUT)-1:0]  done_wait;
   logic                            done_timeout;
   logic [7:0]                      timeout_cnt;

   // Queue side.
   modport slave (
      input  in_valid, in_key, ack,
      output in_ready, req, req_key,
             done_valid, done_key, done_wait, done_timeout, timeout_cnt
   );

   // Upstream producer plus downstream matcher side.
   modport master (
      output in_valid, in_key, ack,
      input  in_ready, req, req_key,
             done_valid, done_key, done_wait, done_timeout, timeout_cnt
   );

endinterface

// File: rtl/key_req_queue_key_fifo.sv
// Circular key store with registered occupancy; the caller never pushes when
// full nor pops when empty, so no overflow protection lives here.
module key_fifo
   import key_req_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int KEY_W = KEY_W_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [KEY_W-1:0] push_key,
   input  logic             pop,
   output logic [KEY_W-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [KEY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_key;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Pointers wrap for free since DEPTH is a power of two.
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/key_req_queue.sv
// Queues keys and presents them one at a time to a downstream matcher,
// retiring each on ack or after TIMEOUT unanswered request cycles.
module key_req_queue
   import key_req_queue_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int KEY_W   = KEY_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic              clk,
   input logic              rst,
   key_req_queue_if.slave   bus
);

   localparam int WAIT_W = wait_width(TIMEOUT);
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                done_valid_q, done_valid_d;
   logic [KEY_W-1:0]    done_key_q, done_key_d;
   logic [WAIT_W-1:0]   done_wait_q, done_wait_d;
   logic                done_timeout_q, done_timeout_d;
   logic [7:0]          timeout_cnt_q, timeout_cnt_d;

   logic                push;
   logic                pop;
   logic [KEY_W-1:0]    fifo_head;
   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_full;
   logic                fifo_empty;
   logic                timed_out;

   assign push = bus.in_valid && !fifo_full;

   key_fifo #(
      .DEPTH (DEPTH),
      .KEY_W (KEY_W)
   ) u_key_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_key (bus.in_key),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // This is the TIMEOUT-th request cycle when the counter already holds TIMEOUT-1.
   assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      pop            = 1'b0;
      done_valid_d   = 1'b0;
      done_key_d     = done_key_q;
      done_wait_d    = done_wait_q;
      done_timeout_d = done_timeout_q;
      timeout_cnt_d  = timeout_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Counting the same-cycle push lets req rise the cycle after the key arrives.
            if (!fifo_empty || push) begin
               state_d = ST_REQ;
               wait_d  = '0;
            end
         end
         ST_REQ: begin
            if (bus.ack || timed_out) begin
               pop            = 1'b1;
               done_valid_d   = 1'b1;
               done_key_d     = fifo_head;
               done_wait_d    = WAIT_W'(wait_q + 1'b1);
               done_timeout_d = !bus.ack;
               if (!bus.ack && timeout_cnt_q != 8'hFF) begin
                  timeout_cnt_d = timeout_cnt_q + 8'd1;
               end
               wait_d  = '0;
               state_d = (fifo_count > CNT_W'(1) || push) ? ST_REQ : ST_IDLE;
            end else begin
               wait_d = WAIT_W'(wait_q + 1'b1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         wait_q         <= '0;
         done_valid_q   <= 1'b0;
         done_key_q     <= '0;
         done_wait_q    <= '0;
         done_timeout_q <= 1'b0;
         timeout_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         done_valid_q   <= done_valid_d;
         done_key_q     <= done_key_d;
         done_wait_q    <= done_wait_d;
         done_timeout_q <= done_timeout_d;
         timeout_cnt_q  <= timeout_cnt_d;
      end
   end

   assign bus.in_ready     = !fifo_full;
   assign bus.req          = (state_q == ST_REQ);
   // Zero while idle so the stale FIFO slot never shows on the bus.
   assign bus.req_key      = (state_q == ST_REQ) ? fifo_head : '0;
   assign bus.done_valid   = done_valid_q;
   assign bus.done_key     = done_key_q;
   assign bus.done_wait    = done_wait_q;
   assign bus.done_timeout = done_timeout_q;
   assign bus.timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_key_req_queue.sv
// Directed bench: a free-running down-counter acts as the downstream matcher,
// expected done timing/waits are worked out by hand from the counter phase.
module tb_key_req_queue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ack_en = 1'b0;
   logic [3:0] dn_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   key_req_queue_if #(.KEY_W(4), .TIMEOUT(16)) bus ();

   key_req_queue #(
      .DEPTH   (4),
      .KEY_W   (4),
      .TIMEOUT (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always_ff @(posedge clk) begin
      if (rst) dn_cnt <= 4'd15;
      else     dn_cnt <= dn_cnt - 4'd1;
   end

   assign bus.ack = ack_en && bus.req && (bus.req_key == dn_cnt);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Leaves the bench at the start of cycle 0 with rst just released.
   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_key   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int exp_key[4]  = '{0, 5, 5, 9};
   int exp_wait[4] = '{15, 11, 16, 12};
   int exp_time[4] = '{16, 27, 43, 55};

   initial begin
      int nd, gaps, nreq, keybad, pushed, ndone, waitbad, sent, rbad, stale;
      int dk[4], dw[4], dto[4], dt[4];
      logic got_done, acc;
      int g_t, g_w, g_to, g_cnt;

      bus.in_valid = 1'b0;
      bus.in_key   = '0;

      // Single key, acked on its first request cycle; also reset values.
      do_reset();
      ack_en       = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_key   = 4'd14;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_req", bus.req, 0);
      check("rst_req_key", bus.req_key, 0);
      check("rst_done_valid", bus.done_valid, 0);
      check("rst_done_key", bus.done_key, 0);
      check("rst_done_wait", bus.done_wait, 0);
      check("rst_done_timeout", bus.done_timeout, 0);
      check("rst_timeout_cnt", bus.timeout_cnt, 0);
      next_cycle();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t1_req", bus.req, 1);
      check("t1_req_key", bus.req_key, 14);
      check("t1_ack", bus.ack, 1);
      next_cycle();
      @(negedge clk);
      check("t1_done_valid", bus.done_valid, 1);
      check("t1_done_key", bus.done_key, 14);
      check("t1_done_wait", bus.done_wait, 1);
      check("t1_done_timeout", bus.done_timeout, 0);
      check("t1_req_after", bus.req, 0);
      next_cycle();
      @(negedge clk);
      check("t1_done_valid_drop", bus.done_valid, 0);
      check("t1_done_key_hold", bus.done_key, 14);
      check("t1_done_wait_hold", bus.done_wait, 1);

      // Back-to-back keys 0,5,5,9; the second 5 is acked on exactly the 16th cycle.
      do_reset();
      ack_en = 1'b1;
      nd     = 0;
      gaps   = 0;
      for (int t = 0; t < 62; t++) begin
         if (t < 4) begin
            bus.in_valid = 1'b1;
            bus.in_key   = 4'(exp_key[t]);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         if (t < 4) check("t2_in_ready", bus.in_ready, 1);
         if (t >= 1 && t <= 54 && !bus.req) gaps++;
         if (bus.done_valid) begin
            if (nd < 4) begin
               dk[nd]  = int'(bus.done_key);
               dw[nd]  = int'(bus.done_wait);
               dto[nd] = int'(bus.done_timeout);
               dt[nd]  = t;
            end
            nd++;
         end
         next_cycle();
      end
      check("t2_req_gaps", gaps, 0);
      check("t2_done_count", nd, 4);
      for (int i = 0; i < 4 && i < nd; i++) begin
         check($sformatf("t2_done_key%0d", i), dk[i], exp_key[i]);
         check($sformatf("t2_done_wait%0d", i), dw[i], exp_wait[i]);
         check($sformatf("t2_done_timeout%0d", i), dto[i], 0);
         check($sformatf("t2_done_cycle%0d", i), dt[i], exp_time[i]);
      end

      // Ack suppressed: key 3 is abandoned after exactly 16 request cycles.
      do_reset();
      ack_en       = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_key   = 4'd3;
      nreq     = 0;
      keybad   = 0;
      got_done = 1'b0;
      g_t = -1; g_w = 0; g_to = 0; g_cnt = 0;
      for (int t = 0; t < 20; t++) begin
         if (t == 1) bus.in_valid = 1'b0;
         @(negedge clk);
         if (bus.req) begin
            nreq++;
            if (bus.req_key != 4'd3) keybad++;
         end
         if (bus.done_valid && !got_done) begin
            got_done = 1'b1;
            g_t   = t;
            g_w   = int'(bus.done_wait);
            g_to  = int'(bus.done_timeout);
            g_cnt = int'(bus.timeout_cnt);
         end
         next_cycle();
      end
      check("t3_req_cycles", nreq, 16);
      check("t3_req_key_stable", keybad, 0);
      check("t3_done_cycle", g_t, 17);
      check("t3_done_wait", g_w, 16);
      check("t3_done_timeout", g_to, 1);
      check("t3_timeout_cnt", g_cnt, 1);

      // 299 more abandoned keys push the counter past its 255 ceiling.
      pushed  = 0;
      ndone   = 1;
      waitbad = 0;
      bus.in_key = 4'd3;
      for (int t = 0; t < 8000 && ndone < 300; t++) begin
         bus.in_valid = (pushed < 299);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) pushed++;
         if (bus.done_valid) begin
            ndone++;
            if (bus.done_wait != 5'd16 || !bus.done_timeout) waitbad++;
         end
         next_cycle();
      end
      bus.in_valid = 1'b0;
      check("t3_bulk_done_count", ndone, 300);
      check("t3_bulk_wait_bad", waitbad, 0);
      check("t3_timeout_cnt_sat", bus.timeout_cnt, 255);

      // Stalled downstream: fifth key waits for the first retire.
      do_reset();
      ack_en = 1'b0;
      sent   = 0;
      rbad   = 0;
      for (int t = 0; t < 20; t++) begin
         bus.in_valid = (sent < 5);
         bus.in_key   = 4'(sent + 1);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (t == 4) check("t4_full_ready", bus.in_ready, 0);
         if (t >= 4 && t <= 16 && bus.in_ready) rbad++;
         if (t == 17) begin
            check("t4_ready_after_pop", bus.in_ready, 1);
            check("t4_accept_with_done", acc, 1);
            check("t4_done_valid", bus.done_valid, 1);
            check("t4_done_key", bus.done_key, 1);
            check("t4_next_req_key", bus.req_key, 2);
         end
         if (acc) sent++;
         next_cycle();
      end
      check("t4_ready_low_span", rbad, 0);
      check("t4_sent", sent, 5);
      bus.in_valid = 1'b0;

      // Reset mid-request with keys queued, then a fresh single-key transaction.
      do_reset();
      ack_en = 1'b0;
      for (int t = 0; t < 5; t++) begin
         bus.in_valid = (t < 4);
         bus.in_key   = 4'(t + 7);
         @(negedge clk);
         next_cycle();
      end
      rst = 1'b1;
      @(negedge clk);
      check("t5_req_before_rst", bus.req, 1);
      next_cycle();
      rst          = 1'b0;
      ack_en       = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_key   = 4'd14;
      @(negedge clk);
      check("t5_req_after_rst", bus.req, 0);
      check("t5_in_ready_after_rst", bus.in_ready, 1);
      check("t5_done_valid_after_rst", bus.done_valid, 0);
      next_cycle();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t5_req", bus.req, 1);
      check("t5_req_key", bus.req_key, 14);
      check("t5_no_stale_done", bus.done_valid, 0);
      next_cycle();
      @(negedge clk);
      check("t5_done_valid", bus.done_valid, 1);
      check("t5_done_key", bus.done_key, 14);
      check("t5_done_wait", bus.done_wait, 1);
      check("t5_done_timeout", bus.done_timeout, 0);
      stale = 0;
      for (int t = 0; t < 20; t++) begin
         next_cycle();
         @(negedge clk);
         if (bus.done_valid || bus.req) stale++;
      end
      check("t5_idle_after", stale, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
